// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// dispatches M-extension ops to an iterative MDU and traps on illegal opcodes or bus timeout.
module multicycle_control_unit #(
  parameter bit          M_EXT       = 1'b1,
  parameter int unsigned BUS_TIMEOUT = 255,
  parameter int unsigned TO_W        = $clog2(BUS_TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instrCode,
  input  logic        busReady,
  input  logic        mdu_done,
  output logic        irEn,
  output logic        pcEn,
  output logic        regFileWe,
  output logic        aluSrcMuxSel,
  output logic [3:0]  aluControl,
  output logic [2:0]  strb,
  output logic        busWe,
  output logic        busRe,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        mdu_start,
  output logic        trap,
  output logic [1:0]  trapCause
);

  localparam int unsigned     CntW   = (TO_W > 0) ? TO_W : 1;
  localparam bit              ToEn   = (BUS_TIMEOUT > 0);
  localparam logic [CntW-1:0] ToLast = CntW'(BUS_TIMEOUT - 1);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpS     = 7'b0100011;
  localparam logic [6:0] OpL     = 7'b0000011;
  localparam logic [6:0] OpB     = 7'b1100011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] F7Mext  = 7'b0000001;

  localparam logic [1:0] CauseNone    = 2'd0;
  localparam logic [1:0] CauseIllegal = 2'd1;
  localparam logic [1:0] CauseTimeout = 2'd2;

  localparam logic [2:0] WdAlu  = 3'd0;
  localparam logic [2:0] WdLoad = 3'd1;
  localparam logic [2:0] WdImm  = 3'd2;
  localparam logic [2:0] WdAuipc = 3'd3;
  localparam logic [2:0] WdPc4  = 3'd4;
  localparam logic [2:0] WdMdu  = 3'd5;

  localparam logic [3:0] AluAdd = 4'b0000;

  typedef enum logic [3:0] {
    StFetch, StDecode, StExeR, StExeI, StExeB, StExeLui, StExeAuipc, StExeJal,
    StExeJalr, StExeS, StMemS, StExeL, StMemL, StWbL, StExeM, StTrap
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] to_cnt_q;
  logic [1:0]      trap_cause_q;
  logic            m_first_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] alu_rb;
  logic [3:0] alu_i;
  logic       unused_instr;

  assign opcode       = instrCode[6:0];
  assign funct3       = instrCode[14:12];
  assign funct7       = instrCode[31:25];
  assign alu_rb       = {instrCode[30], funct3};
  // Only SRAI carries the instr[30] modifier among immediate ops.
  assign alu_i        = ((funct3 == 3'b101) && instrCode[30]) ? {1'b1, funct3} : {1'b0, funct3};
  assign unused_instr = ^{instrCode[24:15], instrCode[11:7]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StFetch;
      to_cnt_q     <= '0;
      trap_cause_q <= CauseNone;
      m_first_q    <= 1'b0;
    end else begin
      case (state_q)
        StFetch: state_q <= StDecode;
        StDecode: begin
          case (opcode)
            OpR: begin
              if (funct7 == F7Mext) begin
                if (M_EXT) begin
                  state_q   <= StExeM;
                  m_first_q <= 1'b1;
                end else begin
                  state_q      <= StTrap;
                  trap_cause_q <= CauseIllegal;
                end
              end else begin
                state_q <= StExeR;
              end
            end
            OpI:     state_q <= StExeI;
            OpS:     state_q <= StExeS;
            OpL:     state_q <= StExeL;
            OpB:     state_q <= StExeB;
            OpLui:   state_q <= StExeLui;
            OpAuipc: state_q <= StExeAuipc;
            OpJal:   state_q <= StExeJal;
            OpJalr:  state_q <= StExeJalr;
            default: begin
              state_q      <= StTrap;
              trap_cause_q <= CauseIllegal;
            end
          endcase
        end
        StExeS: begin
          state_q  <= StMemS;
          to_cnt_q <= '0;
        end
        StExeL: begin
          state_q  <= StMemL;
          to_cnt_q <= '0;
        end
        StMemS, StMemL: begin
          // A ready on the expiring cycle still completes the access.
          if (busReady) begin
            state_q <= (state_q == StMemS) ? StFetch : StWbL;
          end else if (ToEn && (to_cnt_q == ToLast)) begin
            state_q      <= StTrap;
            trap_cause_q <= CauseTimeout;
          end else begin
            to_cnt_q <= to_cnt_q + CntW'(1);
          end
        end
        StExeM: begin
          m_first_q <= 1'b0;
          if (mdu_done) state_q <= StFetch;
        end
        StTrap:  state_q <= StTrap;
        default: state_q <= StFetch;
      endcase
    end
  end

  always_comb begin
    irEn          = 1'b0;
    pcEn          = 1'b0;
    regFileWe     = 1'b0;
    aluSrcMuxSel  = 1'b0;
    aluControl    = AluAdd;
    busWe         = 1'b0;
    busRe         = 1'b0;
    RFWDSrcMuxSel = WdAlu;
    branch        = 1'b0;
    jal           = 1'b0;
    mdu_start     = 1'b0;
    trap          = 1'b0;
    case (state_q)
      StFetch: irEn = 1'b1;
      StExeR: begin
        pcEn       = 1'b1;
        regFileWe  = 1'b1;
        aluControl = alu_rb;
      end
      StExeI: begin
        pcEn         = 1'b1;
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        aluControl   = alu_i;
      end
      StExeB: begin
        pcEn       = 1'b1;
        branch     = 1'b1;
        aluControl = alu_rb;
      end
      StExeLui: begin
        pcEn          = 1'b1;
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = WdImm;
      end
      StExeAuipc: begin
        pcEn          = 1'b1;
        regFileWe     = 1'b1;
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = WdAuipc;
      end
      StExeJal: begin
        pcEn          = 1'b1;
        regFileWe     = 1'b1;
        jal           = 1'b1;
        RFWDSrcMuxSel = WdPc4;
      end
      StExeJalr: begin
        pcEn          = 1'b1;
        regFileWe     = 1'b1;
        jal           = 1'b1;
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = WdPc4;
      end
      StExeS, StExeL: aluSrcMuxSel = 1'b1;
      StMemS: begin
        aluSrcMuxSel = 1'b1;
        busWe        = 1'b1;
        pcEn         = busReady;
      end
      StMemL: begin
        aluSrcMuxSel = 1'b1;
        busRe        = 1'b1;
      end
      StWbL: begin
        pcEn          = 1'b1;
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = WdLoad;
      end
      StExeM: begin
        mdu_start = m_first_q;
        if (mdu_done) begin
          pcEn          = 1'b1;
          regFileWe     = 1'b1;
          RFWDSrcMuxSel = WdMdu;
        end
      end
      StTrap:  trap = 1'b1;
      default: ;
    endcase
  end

  assign strb      = funct3;
  assign trapCause = trap_cause_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected output traces built from
// instruction-class rules, directed cases followed by randomized instruction streams.
module tb_multicycle_control_unit;

  localparam int Timeout = 4;

  typedef struct packed {
    logic       ir, pc, we, asrc;
    logic [3:0] alu;
    logic       bwe, bre;
    logic [2:0] wd;
    logic       br, jl, ms, tr;
    logic [1:0] cause;
    logic [2:0] strb;
  } vec_t;

  typedef struct packed {
    vec_t e;
    bit   rdy;
    bit   done;
  } step_t;

  logic clk, reset_n, rst0_n;
  logic [31:0] instrCode;
  logic busReady, mdu_done;

  logic irEn, pcEn, regFileWe, aluSrcMuxSel, busWe, busRe, branch, jal, mdu_start, trap;
  logic [3:0] aluControl;
  logic [2:0] strb, RFWDSrcMuxSel;
  logic [1:0] trapCause;

  logic irEn0, pcEn0, regFileWe0, aluSrcMuxSel0, busWe0, busRe0, branch0, jal0, mdu_start0, trap0;
  logic [3:0] aluControl0;
  logic [2:0] strb0, RFWDSrcMuxSel0;
  logic [1:0] trapCause0;

  multicycle_control_unit #(.M_EXT(1'b1), .BUS_TIMEOUT(Timeout)) dut (
    .clk(clk), .reset_n(reset_n), .instrCode(instrCode), .busReady(busReady),
    .mdu_done(mdu_done), .irEn(irEn), .pcEn(pcEn), .regFileWe(regFileWe),
    .aluSrcMuxSel(aluSrcMuxSel), .aluControl(aluControl), .strb(strb), .busWe(busWe),
    .busRe(busRe), .RFWDSrcMuxSel(RFWDSrcMuxSel), .branch(branch), .jal(jal),
    .mdu_start(mdu_start), .trap(trap), .trapCause(trapCause)
  );

  multicycle_control_unit #(.M_EXT(1'b0), .BUS_TIMEOUT(0)) dut0 (
    .clk(clk), .reset_n(rst0_n), .instrCode(instrCode), .busReady(busReady),
    .mdu_done(mdu_done), .irEn(irEn0), .pcEn(pcEn0), .regFileWe(regFileWe0),
    .aluSrcMuxSel(aluSrcMuxSel0), .aluControl(aluControl0), .strb(strb0), .busWe(busWe0),
    .busRe(busRe0), .RFWDSrcMuxSel(RFWDSrcMuxSel0), .branch(branch0), .jal(jal0),
    .mdu_start(mdu_start0), .trap(trap0), .trapCause(trapCause0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  step_t q[$];

  function automatic vec_t obs();
    return {irEn, pcEn, regFileWe, aluSrcMuxSel, aluControl, busWe, busRe, RFWDSrcMuxSel,
            branch, jal, mdu_start, trap, trapCause, strb};
  endfunction

  function automatic vec_t obs0();
    return {irEn0, pcEn0, regFileWe0, aluSrcMuxSel0, aluControl0, busWe0, busRe0,
            RFWDSrcMuxSel0, branch0, jal0, mdu_start0, trap0, trapCause0, strb0};
  endfunction

  function automatic vec_t blank(input logic [31:0] ins);
    vec_t v;
    v = '0;
    v.strb = ins[14:12];
    return v;
  endfunction

  // rdy/done < 0 means "don't care": drive random noise the DUT must ignore.
  function automatic void push(input vec_t v, input int rdy, input int done);
    step_t s;
    s.e    = v;
    s.rdy  = (rdy < 0) ? ($urandom_range(0, 1) == 1) : (rdy != 0);
    s.done = (done < 0) ? ($urandom_range(0, 1) == 1) : (done != 0);
    q.push_back(s);
  endfunction

  task automatic check(input string tag, input vec_t o, input vec_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011, 7'b1100011,
                      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
  endfunction

  // Expected cycle-by-cycle trace; waits = stall cycles before bus ready / mdu_done.
  function automatic bit build(input logic [31:0] ins, input int waits);
    vec_t v;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [3:0] rb_alu = {ins[30], f3};
    logic [3:0] i_alu = (f3 == 3'b101 && ins[30]) ? {1'b1, f3} : {1'b0, f3};
    bit trapped = 1'b0;
    bit ld;
    int nmem;
    q.delete();
    v = blank(ins); v.ir = 1'b1; push(v, -1, -1);
    v = blank(ins); push(v, -1, -1);
    v = blank(ins);
    case (op)
      7'b0110011: begin
        if (ins[31:25] == 7'b0000001) begin
          for (int j = 0; j <= waits; j++) begin
            v = blank(ins);
            v.ms = (j == 0);
            if (j == waits) begin v.we = 1'b1; v.wd = 3'd5; v.pc = 1'b1; end
            push(v, -1, (j == waits) ? 1 : 0);
          end
        end else begin
          v.pc = 1'b1; v.we = 1'b1; v.alu = rb_alu; push(v, -1, -1);
        end
      end
      7'b0010011: begin v.pc = 1'b1; v.we = 1'b1; v.asrc = 1'b1; v.alu = i_alu; push(v, -1, -1); end
      7'b1100011: begin v.pc = 1'b1; v.br = 1'b1; v.alu = rb_alu; push(v, -1, -1); end
      7'b0110111: begin v.pc = 1'b1; v.we = 1'b1; v.wd = 3'd2; push(v, -1, -1); end
      7'b0010111: begin v.pc = 1'b1; v.we = 1'b1; v.asrc = 1'b1; v.wd = 3'd3; push(v, -1, -1); end
      7'b1101111: begin v.pc = 1'b1; v.we = 1'b1; v.jl = 1'b1; v.wd = 3'd4; push(v, -1, -1); end
      7'b1100111: begin
        v.pc = 1'b1; v.we = 1'b1; v.jl = 1'b1; v.asrc = 1'b1; v.wd = 3'd4; push(v, -1, -1);
      end
      7'b0100011, 7'b0000011: begin
        ld = (op == 7'b0000011);
        v.asrc = 1'b1; push(v, -1, -1);
        nmem = (waits >= Timeout) ? Timeout : waits + 1;
        for (int j = 0; j < nmem; j++) begin
          v = blank(ins);
          v.asrc = 1'b1; v.bwe = !ld; v.bre = ld;
          if (!ld && j == waits) v.pc = 1'b1;
          push(v, (j == waits) ? 1 : 0, -1);
        end
        if (waits >= Timeout) begin
          for (int j = 0; j < 2; j++) begin
            v = blank(ins); v.tr = 1'b1; v.cause = 2'd2; push(v, 0, -1);
          end
          trapped = 1'b1;
        end else if (ld) begin
          v = blank(ins); v.we = 1'b1; v.wd = 3'd1; v.pc = 1'b1; push(v, -1, -1);
        end
      end
      default: begin
        for (int j = 0; j < 2; j++) begin
          v = blank(ins); v.tr = 1'b1; v.cause = 2'd1; push(v, 0, -1);
        end
        trapped = 1'b1;
      end
    endcase
    return trapped;
  endfunction

  // Entered at a falling edge with reset_n low already or state FETCH pending.
  task automatic do_reset(input bit en0);
    vec_t v;
    reset_n = 1'b0;
    rst0_n  = 1'b0;
    #1;
    v = blank(instrCode); v.ir = 1'b1;
    check("reset", obs(), v);
    @(negedge clk);
    reset_n = 1'b1;
    rst0_n  = en0;
  endtask

  // Starts at a falling edge with the DUT in FETCH; abort_at >= 0 pulses reset mid-cycle.
  task automatic do_instr(input string tag, input logic [31:0] ins, input int waits,
                          input int abort_at, output bit trapped);
    vec_t v;
    instrCode = ins;
    trapped = build(ins, waits);
    for (int i = 0; i < q.size(); i++) begin
      busReady = q[i].rdy;
      mdu_done = q[i].done;
      #1;
      check($sformatf("%s[%0d]", tag, i), obs(), q[i].e);
      if (i == abort_at) begin
        #1 reset_n = 1'b0;
        #1;
        v = blank(ins); v.ir = 1'b1;
        check($sformatf("%s_async_reset", tag), obs(), v);
        @(negedge clk);
        reset_n = 1'b1;
        trapped = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 10);
    case (k)
      0: r[6:0] = 7'b0110011;
      1: begin r[6:0] = 7'b0110011; r[31:25] = 7'b0000001; end
      2: r[6:0] = 7'b0010011;
      3: r[6:0] = 7'b0100011;
      4: r[6:0] = 7'b0000011;
      5: r[6:0] = 7'b1100011;
      6: r[6:0] = 7'b0110111;
      7: r[6:0] = 7'b0010111;
      8: r[6:0] = 7'b1101111;
      9: r[6:0] = 7'b1100111;
      default: while (is_legal(r[6:0])) r[6:0] = 7'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    bit tr;
    vec_t v;
    logic [31:0] ins;
    reset_n = 1'b0; rst0_n = 1'b0;
    instrCode = 32'h0; busReady = 1'b0; mdu_done = 1'b0;
    @(negedge clk);
    do_reset(1'b0);

    do_instr("add", 32'h002081B3, 0, -1, tr);
    do_instr("lw", 32'h0000A283, 2, -1, tr);

    do_reset(1'b1);
    do_instr("sw_timeout", 32'h0020A223, Timeout, -1, tr);
    busReady = 1'b0;
    #1;
    v = blank(32'h0020A223); v.asrc = 1'b1; v.bwe = 1'b1;
    check("no_timeout_when_disabled", obs0(), v);
    @(negedge clk);
    do_reset(1'b1);
    do_instr("mul", 32'h022081B3, 5, -1, tr);
    v = blank(32'h022081B3); v.tr = 1'b1; v.cause = 2'd1;
    check("mul_without_mext", obs0(), v);
    do_reset(1'b0);

    do_instr("srai", 32'h4020D193, 0, -1, tr);
    do_instr("srli", 32'h0020D193, 0, -1, tr);
    do_instr("beq", 32'h00208463, 0, -1, tr);
    do_instr("sw_ready_at_expiry", 32'h0020A223, Timeout - 1, -1, tr);
    do_instr("illegal", 32'hFFFFFFFF, 0, -1, tr);
    do_reset(1'b0);
    do_instr("lw_abort", 32'h0000A283, 3, 3, tr);
    do_instr("add_after_abort", 32'h002081B3, 0, -1, tr);
    do_instr("mul_done_on_entry", 32'h022081B3, 0, -1, tr);

    for (int n = 0; n < 200; n++) begin
      ins = rand_instr();
      do_instr($sformatf("rnd%0d_%h", n, ins), ins, $urandom_range(0, 6), -1, tr);
      if (tr) do_reset(1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- FSM-based RV32I control unit for the multi-cycle core. Successor to the single-cycle decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB and stalls on a bus ready handshake.
- Optional M-extension dispatch to an iterative multiply/divide unit (MDU) via start/done handshake.
- Traps on illegal opcodes and on bus timeout. Drives the datapath's pc/IR enables, register file, ALU and bus controls.

Parameters:
- M_EXT, 1: 1 = funct7 0000001 R-type dispatched to MDU; 0 = treated as illegal.
- BUS_TIMEOUT, 255: max consecutive busReady=0 cycles in a MEM state before trap; 0 disables the timeout.
- TO_W, $clog2(BUS_TIMEOUT+1): timeout counter width (derived).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- instrCode  in  32  IR contents, valid from DECODE onward
- busReady  in  1  bus completes the current access this cycle
- mdu_done  in  1  MDU result valid, one-cycle pulse
- irEn  out  1  load IR from instruction memory
- pcEn  out  1  update PC (next-PC mux in datapath)
- regFileWe  out  1  register file write
- aluSrcMuxSel  out  1  0 = rs2, 1 = immediate
- aluControl  out  4  ALU op
- strb  out  3  = instrCode[14:12]
- busWe  out  1  store request
- busRe  out  1  load request
- RFWDSrcMuxSel  out  3  0 ALU, 1 load data, 2 imm (LUI), 3 PC+imm, 4 PC+4, 5 MDU
- branch  out  1  branch-compare PC select
- jal  out  1  jump PC select
- mdu_start  out  1  one-cycle MDU launch
- trap  out  1  sticky error flag
- trapCause  out  2  0 none, 1 illegal, 2 bus timeout

Behaviour:
- States: FETCH, DECODE, EXE_R, EXE_I, EXE_B, EXE_LUI, EXE_AUIPC, EXE_JAL, EXE_JALR, EXE_S, MEM_S, EXE_L, MEM_L, WB_L, EXE_M, TRAP.
- Outputs are combinational from state and instrCode. All outputs are 0 unless listed for the state.
- Reset (async, any time including mid-access or mid-MDU): state=FETCH, timeout counter=0, trapCause=0. Outputs in reset: irEn=1, all others 0 (strb tracks instrCode). busWe/busRe/mdu_start drop immediately.
- FETCH: irEn=1 -> DECODE.
- DECODE: branch on opcode. R 0110011 (funct7 0000001 with M_EXT=1 -> EXE_M), I 0010011, S 0100011 -> EXE_S, L 0000011 -> EXE_L, B 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111. Any other opcode -> TRAP with cause 1.
- Single-cycle EXE states (R, I, B, LUI, AUIPC, JAL, JALR): pcEn=1, then -> FETCH. regFileWe=1 for all except B.
  - aluSrcMuxSel=1 for I, AUIPC, JALR.
  - RFWDSrcMuxSel: 0 (R/I), 2 (LUI), 3 (AUIPC), 4 (JAL/JALR).
  - branch=1 in B. jal=1 in JAL/JALR.
- aluControl:
  - R and B: {instr[30], funct3}.
  - I: {instr[30], funct3} only when funct3=101 and instr[30]=1 (SRAI); otherwise {0, funct3}.
  - All other states: 0000 (ADD).
- Store: EXE_S (aluSrcMuxSel=1) -> MEM_S. MEM_S holds aluSrcMuxSel=1 and busWe=1 while waiting.
  - busReady=1: pcEn=1 -> FETCH.
  - Ready in the first MEM cycle gives 4-cycle total latency.
- Load: EXE_L (aluSrcMuxSel=1) -> MEM_L. MEM_L holds aluSrcMuxSel=1 and busRe=1 until busReady -> WB_L.
  - WB_L: regFileWe=1, RFWDSrcMuxSel=1, pcEn=1 -> FETCH. Minimum latency 5 cycles.
- Timeout: counter clears on entry to a MEM state and increments each busReady=0 cycle.
  - If BUS_TIMEOUT>0 and the counter reaches BUS_TIMEOUT with busReady still 0: -> TRAP, cause 2, no pcEn.
  - busReady=1 on the same cycle the count would expire completes the access normally.
- EXE_M: mdu_start=1 on the first cycle only (entry cycle), then wait.
  - mdu_done=1: regFileWe=1, RFWDSrcMuxSel=5, pcEn=1 -> FETCH.
  - mdu_done on the entry cycle is accepted (completes same cycle).
- TRAP: trap=1, all enables 0. Held until reset_n asserted; trapCause holds.

Test Plan:
- add 0x002081B3: FETCH, DECODE, EXE_R -> cycle 3 regFileWe=1, aluControl=0000, RFWDSrcMuxSel=0, pcEn=1, back to FETCH.
- lw 0x0000A283, busReady low 2 cycles -> busRe=1 for 3 cycles, then WB_L with regFileWe=1, RFWDSrcMuxSel=1, strb=010; 7 cycles total.
- sw 0x0020A223, BUS_TIMEOUT=4, busReady stuck 0 -> busWe for 4 cycles, then trap=1, trapCause=2, pcEn never asserted; reset_n clears it.
- mul 0x022081B3, M_EXT=1, mdu_done on 6th EXE_M cycle -> single mdu_start pulse, regFileWe with RFWDSrcMuxSel=5 on the done cycle. With M_EXT=0 -> trapCause=1.
- srai 0x4020D193 -> aluControl=1101; srli 0x0020D193 -> 0101; beq 0x00208463 -> branch=1, regFileWe=0.
- Illegal 0xFFFFFFFF -> TRAP after DECODE. Separately, reset_n pulsed low mid-MEM_L -> busRe drops asynchronously, irEn=1, state FETCH.
